// File: rtl/axi_bti_ro_slave_regs.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : axi_bti_ro_slave_regs
// Description : AXI4-Lite register slave for a ring-oscillator BTI monitor.
//               It counts ro_tick strobes over a programmable window of
//               clock cycles. Register map (word index = ADDR[4:2]):
//                 0 CTRL     RW  bit0 start (from IDLE), bit1 abort (in COUNT)
//                 1 WINDOW   RW  measurement length in clock cycles
//                 2 SCRATCH0 RW
//                 3 SCRATCH1 RW
//                 4 COUNT    RO  saturating tick count
//                 5 STATUS   RO  {ovf, done, busy}
//                 6-7        unmapped, read as 0, writes ignored
// Ports       : S_AXI_ACLK / S_AXI_ARESETN   clock, sync active-low reset
//               S_AXI_AW*/W*/B*             AXI4-Lite write channels
//               S_AXI_AR*/R*                AXI4-Lite read channels
//               ro_tick                     one-cycle strobe per RO edge
//               ro_enable                   high while counting
//               meas_done                   one-cycle completion pulse
// Config      : define BTI_RO_SLV_WSTRB_EN to honour WSTRB byte enables;
//               without it every write updates all four bytes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module axi_bti_ro_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              ro_tick,
    output logic                              ro_enable,
    output logic                              meas_done
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_WINDOW   = 3'd1;
    localparam logic [2:0] IDX_SCRATCH0 = 3'd2;
    localparam logic [2:0] IDX_SCRATCH1 = 3'd3;
    localparam logic [2:0] IDX_COUNT    = 3'd4;
    localparam logic [2:0] IDX_STATUS   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DW-1:0]     ctrl_reg;
    logic [DW-1:0]     window_reg;
    logic [DW-1:0]     scratch0_reg;
    logic [DW-1:0]     scratch1_reg;
    logic [DW-1:0]     count_reg;
    logic [DW-1:0]     win_cnt;
    logic              ovf;
    logic              done;
    logic              busy;

    logic [2:0]        wr_idx;
    logic [2:0]        rd_idx;
    logic              wr_en;
    logic              rd_en;
    logic [STRB_W-1:0] byte_en;
    logic              start_req;
    logic              abort_req;
    logic [DW-1:0]     rd_mux;
    logic              unused_inputs;

    assign wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1 -: 3];
    assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1 -: 3];

`ifdef BTI_RO_SLV_WSTRB_EN
    assign byte_en       = S_AXI_WSTRB;
    assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign byte_en       = '1;
    assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};
`endif

    // The ready pulses are the handshake cycle; the master holds its
    // address/data valid until then, so the bus can be sampled directly.
    assign wr_en = S_AXI_AWREADY && S_AXI_WREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en = S_AXI_ARREADY && S_AXI_ARVALID;

    // Control bits only act when their byte lane is actually written.
    assign start_req = wr_en && (wr_idx == IDX_CTRL) && byte_en[0] &&
                       S_AXI_WDATA[0] && (state == ST_IDLE);
    assign abort_req = wr_en && (wr_idx == IDX_CTRL) && byte_en[0] &&
                       S_AXI_WDATA[1] && (state == ST_COUNT);

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]     old_val,
                                                  input logic [DW-1:0]     new_val,
                                                  input logic [STRB_W-1:0] be);
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            IDX_CTRL:     rd_mux = ctrl_reg;
            IDX_WINDOW:   rd_mux = window_reg;
            IDX_SCRATCH0: rd_mux = scratch0_reg;
            IDX_SCRATCH1: rd_mux = scratch1_reg;
            IDX_COUNT:    rd_mux = count_reg;
            IDX_STATUS:   rd_mux = {{(DW-3){1'b0}}, ovf, done, busy};
            default:      rd_mux = '0;
        endcase
    end

    //--------------------------------------------------------------------------
    // Measurement FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ro_enable  = 1'b0;
        meas_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                ro_enable = 1'b1;
                if (abort_req) begin
                    state_next = ST_IDLE;
                end else if (win_cnt <= {{(DW-1){1'b0}}, 1'b1}) begin
                    // A zero window also leaves after a single cycle.
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                meas_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // AXI channels, register file and measurement datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            ctrl_reg      <= '0;
            window_reg    <= '0;
            scratch0_reg  <= '0;
            scratch1_reg  <= '0;
            count_reg     <= '0;
            win_cnt       <= '0;
            ovf           <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Write: single-cycle ready pulse, blocked while a response is
            // outstanding and never back-to-back.
            S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
            S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
            S_AXI_BRESP   <= 2'b00;
            if (wr_en) begin
                S_AXI_BVALID <= 1'b1;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (wr_en) begin
                case (wr_idx)
                    IDX_CTRL:     ctrl_reg     <= merge_bytes(ctrl_reg, S_AXI_WDATA, byte_en);
                    IDX_WINDOW:   window_reg   <= merge_bytes(window_reg, S_AXI_WDATA, byte_en);
                    IDX_SCRATCH0: scratch0_reg <= merge_bytes(scratch0_reg, S_AXI_WDATA, byte_en);
                    IDX_SCRATCH1: scratch1_reg <= merge_bytes(scratch1_reg, S_AXI_WDATA, byte_en);
                    default: ;
                endcase
            end

            // Read: data captured on the handshake edge, so a STATUS read in
            // the DONE cycle sees the value before done/busy update.
            S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
            S_AXI_RRESP   <= 2'b00;
            if (rd_en) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end

            // The running window is a private copy, so WINDOW writes during
            // a measurement only affect the next one.
            if (start_req) begin
                win_cnt   <= window_reg;
                count_reg <= '0;
                ovf       <= 1'b0;
                done      <= 1'b0;
                busy      <= 1'b1;
            end else if (state == ST_COUNT) begin
                if (abort_req) begin
                    busy <= 1'b0;
                end else if (win_cnt != '0) begin
                    win_cnt <= win_cnt - {{(DW-1){1'b0}}, 1'b1};
                    if (ro_tick) begin
                        if (count_reg == '1) begin
                            ovf <= 1'b1;
                        end else begin
                            count_reg <= count_reg + {{(DW-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end else if (state == ST_DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_bti_ro_slave_regs.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_axi_bti_ro_slave_regs
// Description : Scoreboard bench for axi_bti_ro_slave_regs. Bus tasks push
//               expected responses from a register-map model; a monitor pops
//               and compares at every B/R handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_axi_bti_ro_slave_regs;

    logic        clk;
    logic        rstn;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        ro_tick;
    logic        ro_enable;
    logic        meas_done;

    axi_bti_ro_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ro_tick       (ro_tick),
        .ro_enable     (ro_enable),
        .meas_done     (meas_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: register contents plus measurement results.
    logic [31:0] m_reg [0:3];
    logic [31:0] m_count;
    logic [2:0]  m_status;

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] mask;
`ifdef BTI_RO_SLV_WSTRB_EN
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`else
        mask = 32'hFFFF_FFFF;
`endif
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int idx = int'(a[4:2]);
        if (idx < 4)       return m_reg[idx];
        else if (idx == 4) return m_count;
        else if (idx == 5) return {29'b0, m_status};
        else               return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        m_count  = 32'h0;
        m_status = 3'b000;
    endtask

    // Scoreboard queues: write responses, and reads as {scored, data}.
    logic [1:0]  exp_b [$];
    logic [32:0] exp_r [$];

    always @(negedge clk) begin
        if (rstn && bvalid && bready) begin
            if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
            else check("bresp", {30'b0, bresp}, {30'b0, exp_b.pop_front()});
        end
        if (rstn && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_r.pop_front();
                check("rresp", {30'b0, rresp}, 32'h0);
                if (e[32]) check("rdata", rdata, e[31:0]);
            end
        end
    end

    // Running totals of enable cycles and done pulses.
    int en_total   = 0;
    int done_total = 0;
    always @(negedge clk) begin
        if (ro_enable) en_total++;
        if (meas_done) done_total++;
    end

    // Tick source: 0 off, 1 every cycle, 2 every second cycle.
    int tick_mode = 0;
    initial begin
        ro_tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tick_mode)
                1:       ro_tick = 1'b1;
                2:       ro_tick = ~ro_tick;
                default: ro_tick = 1'b0;
            endcase
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold);
        bit got;
        logic [1:0] resp0;
        if (a[4:2] < 3'd4) m_reg[a[4:2]] = apply_strb(m_reg[a[4:2]], d, s);
        exp_b.push_back(2'b00);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (awready || wready) begin got = 1'b1; break; end
        end
        check("aw_handshake", {31'b0, got}, 32'd1);
        if (got) check("aw_w_together", {30'b0, awready, wready}, 32'h3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("awready_single", {31'b0, awready}, 32'd0);
        check("bvalid_rise", {31'b0, bvalid}, 32'd1);
        for (int k = 0; k < 20 && !bvalid; k++) @(negedge clk);
        resp0 = bresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("bvalid_hold", {31'b0, bvalid}, 32'd1);
            check("bresp_hold", {30'b0, bresp}, {30'b0, resp0});
        end
        @(posedge clk); #1; bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; bready = 1'b0;
        @(negedge clk);
        check("bvalid_clear", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [4:0] a, input int hold, input bit scored,
                            output logic [31:0] data);
        bit got;
        exp_r.push_back({scored, model_read(a)});
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (arready) begin got = 1'b1; break; end
        end
        check("ar_handshake", {31'b0, got}, 32'd1);
        @(posedge clk); #1; arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_rise", {31'b0, rvalid}, 32'd1);
        for (int k = 0; k < 20 && !rvalid; k++) @(negedge clk);
        data = rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("rvalid_hold", {31'b0, rvalid}, 32'd1);
            check("rdata_hold", rdata, data);
        end
        @(posedge clk); #1; rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; rready = 1'b0;
        @(negedge clk);
        check("rvalid_clear", {31'b0, rvalid}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {awready, wready, bvalid, arready, rvalid, ro_enable, meas_done,
                     bresp, rresp}, 32'h0);
        check({name, "_rdata"}, rdata, 32'h0);
    endtask

    int e0, d0;

    task automatic start_meas(input logic [31:0] w, input int mode);
        tick_mode = mode;
        e0 = en_total;
        d0 = done_total;
        axi_write(5'h04, w, 4'hF, 0);
        axi_write(5'h00, 32'h1, 4'hF, 0);
        m_status = 3'b001;
        m_count  = 32'h0;
    endtask

    // Completion: enable must have been high for max(window,1) cycles with
    // exactly one done pulse.
    task automatic finish_meas(input int en_exp, input logic [31:0] cnt_exp);
        logic [31:0] rd;
        for (int k = 0; k < 500 && done_total == d0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("meas_done_pulses", done_total - d0, 32'd1);
        check("ro_enable_cycles", en_total - e0, en_exp);
        m_count  = cnt_exp;
        m_status = 3'b010;
        tick_mode = 0;
        axi_read(5'h10, 0, 1'b1, rd);
        axi_read(5'h14, 0, 1'b1, rd);
    endtask

    logic [31:0] rd, rd2;
    logic [2:0]  ridx;
    logic [1:0]  rlow;
    int          w;

    initial begin
        rstn = 1'b0; awaddr = '0; awprot = 3'b101; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = 3'b010; arvalid = 1'b0;
        rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        @(posedge clk); #1; rstn = 1'b1;

        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 0, 1'b1, rd);

        // Basic write/read-back. CTRL=1 with WINDOW still 0 runs a one-cycle
        // measurement that ends with COUNT=0 and STATUS.done.
        d0 = done_total;
        axi_write(5'h00, 32'h1, 4'hF, 0);
        m_status = 3'b010;
        axi_write(5'h04, 32'h2, 4'hF, 0);
        axi_write(5'h08, 32'h3, 4'hF, 0);
        axi_write(5'h0C, 32'h4, 4'hF, 0);
        for (int i = 0; i < 6; i++) axi_read(5'(i * 4), 0, 1'b1, rd);
        check("first_start_done", done_total - d0, 32'd1);

        // Randomized register traffic; CTRL bit0 kept clear so nothing starts.
        for (int i = 0; i < 40; i++) begin
            ridx = 3'($urandom_range(0, 7));
            rlow = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom;
                if (ridx == 3'd0) rd[0] = 1'b0;
                axi_write({ridx, rlow}, rd, 4'($urandom), $urandom_range(0, 2));
            end else begin
                axi_read({ridx, rlow}, $urandom_range(0, 2), 1'b1, rd);
            end
        end

        // Window 10, tick every other cycle.
        start_meas(32'd10, 2);
        finish_meas(10, 32'd5);

        // Random windows with a constant tick, then the zero window.
        for (int i = 0; i < 4; i++) begin
            w = $urandom_range(1, 30);
            start_meas(32'(w), 1);
            finish_meas(w, 32'(w));
        end
        start_meas(32'd0, 1);
        finish_meas(1, 32'd0);
        axi_read(5'h18, 0, 1'b1, rd);
        axi_read(5'h1C, 0, 1'b1, rd);
        axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, 0);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(5'h18, 32'h1234_5678, 4'hF, 0);
        axi_read(5'h10, 0, 1'b1, rd);
        axi_read(5'h14, 0, 1'b1, rd);

        // Restart and WINDOW writes during COUNT must not disturb the run.
        start_meas(32'd80, 1);
        axi_read(5'h14, 0, 1'b1, rd);
        axi_write(5'h04, 32'd3, 4'hF, 0);
        axi_write(5'h00, 32'h1, 4'hF, 0);
        finish_meas(80, 32'd80);

        // Abort around cycle 20 of a 100-cycle window.
        start_meas(32'd100, 1);
        repeat (15) @(posedge clk);
        axi_write(5'h00, 32'h2, 4'hF, 0);
        m_status = 3'b000;
        repeat (3) @(negedge clk);
        check("abort_ro_enable", {31'b0, ro_enable}, 32'd0);
        axi_read(5'h14, 0, 1'b1, rd);
        axi_read(5'h10, 0, 1'b0, rd);
        check("abort_count_range", {31'b0, (rd >= 32'd12 && rd <= 32'd35)}, 32'd1);
        repeat (110) @(negedge clk);
        check("abort_no_done", done_total - d0, 32'd0);
        tick_mode = 0;

        // Byte strobes.
        axi_write(5'h08, 32'hAABB_CCDD, 4'hF, 0);
        axi_write(5'h08, 32'h1122_3344, 4'b0001, 0);
        axi_read(5'h08, 0, 1'b1, rd);
`ifdef BTI_RO_SLV_WSTRB_EN
        check("wstrb_merge", rd, 32'hAABB_CC44);
`else
        check("wstrb_merge", rd, 32'h1122_3344);
`endif

        // Back-pressure on B and R.
        axi_write(5'h0C, 32'h5A5A_0F0F, 4'hF, 5);
        axi_read(5'h0C, 5, 1'b1, rd);

        // Concurrent write and read on different registers.
        fork
            axi_write(5'h08, 32'hCAFE_F00D, 4'hF, 1);
            axi_read(5'h04, 1, 1'b1, rd2);
        join
        axi_read(5'h08, 0, 1'b1, rd);

        // Reset in the middle of a measurement.
        start_meas(32'd100, 1);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midreset_outputs");
        @(posedge clk); #1; rstn = 1'b1;
        tick_mode = 0;
        model_reset();
        repeat (110) @(negedge clk);
        check("midreset_no_done", done_total - d0, 32'd0);
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 0, 1'b1, rd);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_b.size() + exp_r.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
